// File: rtl/konami_504_pkg.sv
// Shared constants for the konami_504 sprite line-buffer scan controller.
// Phase codes are matched against hph = {8H,4H,2H,1H}.
package konami_504_pkg;
    localparam int ADDR_W = 8;
    localparam int OBJ_W  = 4;

    localparam logic [1:0] PH_WE   = 2'b01;
    localparam logic [1:0] PH_STEP = 2'b11;
    localparam logic [3:0] PH_OBJ  = 4'b1111;
endpackage

// File: rtl/konami_504_scan_ctr.sv
// Scan address (up/down) and object index counters with a shared synchronous load.
// Load beats counting so the line always restarts from zero outside the scan window.
module konami_504_scan_ctr
    import konami_504_pkg::*;
(
    input  logic              clk_sys,
    input  logic              rst_b,
    input  logic              load,
    input  logic              step,
    input  logic              obj_step,
    input  logic              down,
    output logic [ADDR_W-1:0] addr,
    output logic [OBJ_W-1:0]  obj
);

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            addr <= '0;
            obj  <= '0;
        end else if (load) begin
            addr <= '0;
            obj  <= '0;
        end else begin
            if (step) begin
                addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
            end
            if (obj_step) begin
                obj <= obj + OBJ_W'(1);
            end
        end
    end

endmodule

// File: rtl/konami_504.sv
// Konami 504 top: horizontal phase decode, registered active-low strobes and pin mapping.
// Ports keep the original DIP pin numbering; pins 14 and 28 (supplies) are absent.
module konami_504
    import konami_504_pkg::*;
(
    input  logic p01_i,
    input  logic p27_i,
    input  logic p05_i,
    input  logic p06_i,
    input  logic p07_i,
    input  logic p08_i,
    input  logic p09_i,
    input  logic p10_i,
    input  logic p11_i,
    input  logic p12_i,
    input  logic p13_i,
    output logic p02_o,
    output logic p03_o,
    output logic p04_o,
    output logic p15_o,
    output logic p16_o,
    output logic p17_o,
    output logic p18_o,
    output logic p19_o,
    output logic p20_o,
    output logic p21_o,
    output logic p22_o,
    output logic p23_o,
    output logic p24_o,
    output logic p25_o,
    output logic p26_o
);

    logic [3:0]        hph;
    logic              run;
    logic              step;
    logic              obj_step;
    logic              we_phase;
    logic              n_latch;
    logic              n_we;
    logic              n_bufoe;
    logic [ADDR_W-1:0] addr;
    logic [OBJ_W-1:0]  obj;

    assign hph      = {p13_i, p12_i, p11_i, p10_i};
    // AFR low is the CPU slot: no counting, no latch or write strobes.
    assign run      = p05_i & ~p08_i;
    assign step     = run & (hph[1:0] == PH_STEP);
    assign obj_step = step & (hph == PH_OBJ);
    assign we_phase = run & p09_i & (hph[1:0] == PH_WE);

    always_ff @(posedge p01_i or negedge p27_i) begin
        if (!p27_i) begin
            n_latch <= 1'b1;
            n_we    <= 1'b1;
            n_bufoe <= 1'b1;
        end else begin
            n_latch <= ~step;
            n_we    <= ~we_phase;
            n_bufoe <= ~(~p05_i & p06_i);
        end
    end

    konami_504_scan_ctr u_scan_ctr (
        .clk_sys  (p01_i),
        .rst_b    (p27_i),
        .load     (p08_i),
        .step     (step),
        .obj_step (obj_step),
        .down     (p07_i),
        .addr     (addr),
        .obj      (obj)
    );

    assign p02_o = n_latch;
    assign p03_o = n_we;
    assign p04_o = n_bufoe;
    assign {p22_o, p21_o, p20_o, p19_o, p18_o, p17_o, p16_o, p15_o} = addr;
    assign {p26_o, p25_o, p24_o, p23_o} = obj;

endmodule

// File: tb/tb_konami_504.sv
// Directed self-checking bench for konami_504; one task per scenario.
`timescale 1ns/1ps
module tb_konami_504;

    logic clk = 1'b0;
    logic rst_n;
    logic afr, rnw, flip, n256h, nvblank;
    logic [3:0] hph;
    logic n_latch, n_we, n_bufoe;
    logic p15, p16, p17, p18, p19, p20, p21, p22;
    logic p23, p24, p25, p26;
    logic [7:0] addr;
    logic [3:0] obj;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign addr = {p22, p21, p20, p19, p18, p17, p16, p15};
    assign obj  = {p26, p25, p24, p23};

    konami_504 dut (
        .p01_i (clk),
        .p27_i (rst_n),
        .p05_i (afr),
        .p06_i (rnw),
        .p07_i (flip),
        .p08_i (n256h),
        .p09_i (nvblank),
        .p10_i (hph[0]),
        .p11_i (hph[1]),
        .p12_i (hph[2]),
        .p13_i (hph[3]),
        .p02_o (n_latch),
        .p03_o (n_we),
        .p04_o (n_bufoe),
        .p15_o (p15), .p16_o (p16), .p17_o (p17), .p18_o (p18),
        .p19_o (p19), .p20_o (p20), .p21_o (p21), .p22_o (p22),
        .p23_o (p23), .p24_o (p24), .p25_o (p25), .p26_o (p26)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        afr = 1'b1; rnw = 1'b1; flip = 1'b1; n256h = 1'b0; nvblank = 1'b1; hph = 4'b1111;
        tick(); tick();
        n_checks++;
        if (addr !== 8'h00 || obj !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_counters addr=%h obj=%h exp addr=00 obj=0", addr, obj);
        end
        n_checks++;
        if ({n_latch, n_we, n_bufoe} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_strobes got=%b exp=111", {n_latch, n_we, n_bufoe});
        end
        afr = 1'b1; rnw = 1'b0; flip = 1'b0; n256h = 1'b0; nvblank = 1'b0; hph = 4'b0000;
        rst_n = 1'b1;
        tick(); tick();
        n_checks++;
        if (addr !== 8'h00 || obj !== 4'h0 || {n_latch, n_we, n_bufoe} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_release addr=%h obj=%h strobes=%b exp 00/0/111",
                     addr, obj, {n_latch, n_we, n_bufoe});
        end
    endtask

    task automatic test_scan_up();
        afr = 1'b1; n256h = 1'b0; flip = 1'b0; nvblank = 1'b0; hph = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (addr !== 8'(i + 1) || n_latch !== 1'b0 || obj !== 4'h0) begin
                n_fail++;
                $display("FAIL scan_up step%0d addr=%h nlatch=%b obj=%h exp addr=%h nlatch=0 obj=0",
                         i, addr, n_latch, obj, 8'(i + 1));
            end
        end
        hph = 4'b0000;
        tick();
        n_checks++;
        if (addr !== 8'h03 || n_latch !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_hold addr=%h nlatch=%b exp addr=03 nlatch=1", addr, n_latch);
        end
    endtask

    task automatic test_flip_wrap();
        n256h = 1'b1; hph = 4'b0000;
        tick();
        n256h = 1'b0; flip = 1'b1; hph = 4'b0011;
        tick();
        n_checks++;
        if (addr !== 8'hFF) begin
            n_fail++;
            $display("FAIL wrap_down addr=%h exp=ff", addr);
        end
        flip = 1'b0;
        tick();
        n_checks++;
        if (addr !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_up addr=%h exp=00", addr);
        end
    endtask

    task automatic test_obj_count();
        n256h = 1'b1; hph = 4'b0000;
        tick();
        n256h = 1'b0; flip = 1'b0; hph = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_checks++;
            if (obj !== 4'(i + 1) || addr !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL obj_count step%0d obj=%h addr=%h exp obj=%h addr=%h",
                         i, obj, addr, 4'(i + 1), 8'(i + 1));
            end
        end
        n256h = 1'b1;
        tick();
        n_checks++;
        if (addr !== 8'h00 || obj !== 4'h0 || n_latch !== 1'b1) begin
            n_fail++;
            $display("FAIL load_priority addr=%h obj=%h nlatch=%b exp 00/0/1", addr, obj, n_latch);
        end
    endtask

    task automatic test_write_strobe();
        afr = 1'b1; n256h = 1'b0; hph = 4'b0001; nvblank = 1'b1;
        tick();
        n_checks++;
        if (n_we !== 1'b0 || n_latch !== 1'b1) begin
            n_fail++;
            $display("FAIL we_active nwe=%b nlatch=%b exp nwe=0 nlatch=1", n_we, n_latch);
        end
        nvblank = 1'b0;
        tick();
        n_checks++;
        if (n_we !== 1'b1) begin
            n_fail++;
            $display("FAIL we_vblank nwe=%b exp=1", n_we);
        end
        nvblank = 1'b1; n256h = 1'b1;
        tick();
        n_checks++;
        if (n_we !== 1'b1) begin
            n_fail++;
            $display("FAIL we_window nwe=%b exp=1", n_we);
        end
    endtask

    task automatic test_cpu_slot();
        n256h = 1'b0; afr = 1'b1; flip = 1'b0; hph = 4'b0011; nvblank = 1'b1;
        tick(); tick();
        afr = 1'b0; rnw = 1'b1;
        tick(); tick();
        n_checks++;
        if (n_bufoe !== 1'b0 || addr !== 8'h02 || obj !== 4'h0 || n_latch !== 1'b1 || n_we !== 1'b1) begin
            n_fail++;
            $display("FAIL cpu_read nbufoe=%b addr=%h obj=%h nlatch=%b nwe=%b exp 0/02/0/1/1",
                     n_bufoe, addr, obj, n_latch, n_we);
        end
        hph = 4'b0001;
        tick();
        n_checks++;
        if (n_we !== 1'b1 || addr !== 8'h02) begin
            n_fail++;
            $display("FAIL cpu_we_forced nwe=%b addr=%h exp nwe=1 addr=02", n_we, addr);
        end
        rnw = 1'b0;
        tick();
        n_checks++;
        if (n_bufoe !== 1'b1) begin
            n_fail++;
            $display("FAIL cpu_write nbufoe=%b exp=1", n_bufoe);
        end
    endtask

    task automatic test_reset_mid_scan();
        afr = 1'b1; n256h = 1'b0; flip = 1'b0; hph = 4'b1111; rnw = 1'b1;
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (addr !== 8'h00 || obj !== 4'h0 || {n_latch, n_we, n_bufoe} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_async addr=%h obj=%h strobes=%b exp 00/0/111",
                     addr, obj, {n_latch, n_we, n_bufoe});
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (addr !== 8'h01 || obj !== 4'h1 || n_latch !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_step addr=%h obj=%h nlatch=%b exp 01/1/0", addr, obj, n_latch);
        end
    endtask

    initial begin
        test_reset();
        test_scan_up();
        test_flip_wrap();
        test_obj_count();
        test_write_strobe();
        test_cpu_slot();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
